// File: rtl/ldm_stm_pkg.sv
// Shared types for the LDM/STM sequencer: FSM state encoding and index-width helper.
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FIN
    } state_e;

    // Width of a register index; a single-register file still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsb_pri_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least significant
// set bit of i_vec, and o_valid when any bit is set.
module lsb_pri_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_valid = |i_vec;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Load/store-multiple sequencer: walks set mask bits in ascending order, one
// req/ack memory transfer per register. Optional base write-back: BASE_WRITEBACK_EN.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  ADDR_W = 16,
    parameter int  NREG   = 8,
    parameter int  PC_IDX = NREG - 1,
    localparam int IDX_W  = idx_width(NREG)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_is_store,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [NREG-1:0]   i_reg_mask,
    input  logic [IDX_W-1:0]  i_base_idx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pc_written,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [IDX_W-1:0]  o_rf_raddr,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output logic              o_rf_we,
    output logic [IDX_W-1:0]  o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_base_wb_we,
    output logic [ADDR_W-1:0] o_base_wb_data
);

    state_e            r_state, w_next_state;
    logic [NREG-1:0]   r_pending;
    logic [ADDR_W-1:0] r_addr;
    logic              r_is_store;
    logic              r_pc_sel;
    logic [IDX_W-1:0]  r_base_idx;
    logic              r_ld_we;
    logic [IDX_W-1:0]  r_ld_idx;
    logic [DATA_W-1:0] r_ld_data;

    logic [IDX_W-1:0]  w_cur;
    logic              w_valid;
    logic              w_accept;
    logic              w_ack;
    logic              w_last;
    logic              w_wb_stall;
    logic [NREG-1:0]   w_pending_nxt;

    lsb_pri_enc #(.N(NREG), .IDX_W(IDX_W)) u_enc (
        .i_vec   (r_pending),
        .o_idx   (w_cur),
        .o_valid (w_valid)
    );

    assign w_accept      = (r_state == IDLE) && i_start;
    assign w_ack         = (r_state == XFER) && w_valid && i_mem_ack;
    assign w_pending_nxt = r_pending & (r_pending - NREG'(1)); // drops the lowest set bit
    assign w_last        = (w_pending_nxt == '0);

`ifdef BASE_WRITEBACK_EN
    // The base write-back shares the register-file port with the final load write.
    assign w_wb_stall = r_ld_we;
`else
    assign w_wb_stall = 1'b0;
    logic w_unused_base_idx;
    assign w_unused_base_idx = ^r_base_idx;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        o_busy         = (r_state != IDLE);
        o_done         = 1'b0;
        o_pc_written   = 1'b0;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        o_rf_raddr     = '0;
        o_rf_we        = r_ld_we;
        o_rf_waddr     = r_ld_idx;
        o_rf_wdata     = r_ld_data;
        o_base_wb_we   = 1'b0;
        o_base_wb_data = '0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next_state = (i_reg_mask != '0) ? XFER : FIN;
            end
            XFER: begin
                o_mem_req   = w_valid;
                o_mem_we    = r_is_store;
                o_mem_addr  = r_addr;
                o_rf_raddr  = w_cur;
                o_mem_wdata = r_is_store ? i_rf_rdata : '0;
                if (!w_valid || (w_ack && w_last)) w_next_state = FIN;
            end
            FIN: begin
                if (!w_wb_stall) begin
                    o_done       = 1'b1;
                    o_pc_written = r_pc_sel;
                    w_next_state = IDLE;
`ifdef BASE_WRITEBACK_EN
                    // r_addr has advanced once per transfer, so it already holds base + popcount.
                    o_base_wb_we   = 1'b1;
                    o_base_wb_data = r_addr;
                    o_rf_we        = 1'b1;
                    o_rf_waddr     = r_base_idx;
                    o_rf_wdata     = DATA_W'(r_addr);
`endif
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending  <= '0;
            r_addr     <= '0;
            r_is_store <= 1'b0;
            r_pc_sel   <= 1'b0;
            r_base_idx <= '0;
            r_ld_we    <= 1'b0;
            r_ld_idx   <= '0;
            r_ld_data  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_ld_we <= w_ack && !r_is_store;
            if (w_ack && !r_is_store) begin
                r_ld_idx  <= w_cur;
                r_ld_data <= i_mem_rdata;
            end
            if (w_accept) begin
                r_pending  <= i_reg_mask;
                r_addr     <= i_base_addr;
                r_is_store <= i_is_store;
                r_pc_sel   <= !i_is_store && i_reg_mask[PC_IDX];
                r_base_idx <= i_base_idx;
            end else if (w_ack) begin
                r_pending <= w_pending_nxt;
                r_addr    <= r_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Parametrised load-multiple / store-multiple sequencer for the multicycle core. Given a base address and a register mask, it walks the set mask bits in ascending register order. For each selected register it performs one memory transfer over a req/ack handshake, reading from or writing to the register file. It generalises the fixed 8-register shift/counter scheme: register count and data width are parameters, zero bits are skipped at no cost, memory stalls are tolerated, and a PC hit is reported.

## Interface

- DATA_W, 16, data and register width
- ADDR_W, 16, word address width
- NREG, 8, register count; mask width; index width IDX_W = $clog2(NREG)
- PC_IDX, NREG-1, register index treated as PC
- clock  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only while busy=0
- is_store  in  1  1 = store-multiple, 0 = load-multiple; captured with start
- base_addr  in  ADDR_W  first transfer address; captured with start
- reg_mask  in  NREG  bit i set = transfer register i; captured with start
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- pc_written  out  1  pulses with done when a load mask included PC_IDX
- mem_req  out  1  transfer request
- mem_we  out  1  1 = write (store)
- mem_addr  out  ADDR_W  transfer address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  transfer accepted/completed this cycle
- mem_rdata  in  DATA_W  load data, valid when mem_ack=1 and mem_we=0
- rf_raddr  out  IDX_W  register-file read index (combinational read)
- rf_rdata  in  DATA_W  register-file read data
- rf_we, rf_waddr (IDX_W), rf_wdata (DATA_W)  out  register-file write port
- base_idx  in  IDX_W  base register index; captured with start
- base_wb_we, base_wb_data (ADDR_W)  out  base write-back (see Configuration)

## Operation

- States: IDLE, XFER, FIN.
- IDLE:
  - start=1 with reg_mask≠0: capture the command; pending←reg_mask, addr←base_addr; go to XFER.
  - start=1 with reg_mask=0: go directly to FIN (no transfers).
- XFER:
  - cur = lowest set bit of pending.
  - mem_req=1, mem_addr=addr, mem_we=is_store, rf_raddr=cur, mem_wdata=rf_rdata.
  - These outputs are held stable until mem_ack.
  - On mem_ack: clear bit cur in pending; addr←addr+1, wrapping mod 2^ADDR_W.
  - On a load ack: register rdata and cur; next cycle rf_we=1, rf_waddr=cur, rf_wdata=rdata.
  - When pending becomes 0 on ack, go to FIN; otherwise stay in XFER.
- FIN: done=1 for one cycle; pc_written=1 if !is_store and mask bit PC_IDX was set; go to IDLE.
- start while busy=1 is ignored; no queueing.
- mem_req is never asserted without a set pending bit.

## Timing

- Reset values: all outputs 0; state IDLE; pending and addr cleared.
- Reset mid-operation: the command is aborted with no further mem_req, rf_we or done.
- busy=1 from the cycle after the start edge through FIN inclusive; busy=0 in IDLE.
- mem_req asserts the cycle after start. With zero-wait ack, throughput is one register per cycle.
- Latency from start to done = 1 + Σ(cycles per transfer); with zero-wait ack this is popcount(mask)+1.
- Final load register write lands in the FIN cycle, coincident with done.
- Empty mask: done pulses the cycle after start; busy is high for exactly that one cycle.
- Address wrap: base 0xFFFF with 2 transfers uses addresses 0xFFFF then 0x0000.

## Configuration

- BASE_WRITEBACK_EN defined:
  - In FIN, base_wb_we=1 and base_wb_data = base_addr + popcount(mask), mod 2^ADDR_W.
  - Drive rf_waddr=base_idx only when no load write is pending; otherwise the base write-back is delayed one cycle, and done moves with it.
- BASE_WRITEBACK_EN undefined: base_wb_we and base_wb_data are tied 0; timing is exactly as above.

## Structure

- Shared package ldm_stm_pkg: state enum (IDLE, XFER, FIN) and the IDX_W derivation function.
- One sub-module, lsb_pri_enc: parametrised lowest-set-bit encoder (NREG → IDX_W index plus valid).

## Test plan

- Load, mask 8'b1000_0101, base 0x0040, ack every cycle -> reads 0x0040/41/42 write r0, r2, r7; done 4 cycles after start; pc_written=1.
- Store, mask 8'b0001_0010, r1=0xAAAA, r4=0x5555, ack delayed 3 cycles each -> writes 0xAAAA@base, 0x5555@base+1; address and data held stable throughout the stall.
- Empty mask -> no mem_req; done the cycle after start; busy high one cycle.
- Base 0xFFFF, mask 8'b0000_0011 -> addresses 0xFFFF, 0x0000; with BASE_WRITEBACK_EN, base_wb_data=0x0001.
- rst_n low during the second transfer of a 4-register load -> outputs 0 immediately; no further rf_we; subsequent command executes normally.
- start pulsed while busy -> ignored; original command completes unchanged.
